disaggregator: RTL and testbench
================================

Name: disaggregator

Overview:
- Inverse of the aggregator. Accepts one wide word of FETCH_WIDTH x DATA_WIDTH bits from an upstream FIFO-style sender. Emits it as FETCH_WIDTH narrow DATA_WIDTH words, one per handshake, into a downstream FIFO-style receiver (e.g. async_fifo1 write side).
- Used to return wide results (leaf indices, patch words) over the same narrow 11-bit FIFO links that feed internal_node_tree.

Parameters:
- DATA_WIDTH, 11, width of one narrow output word.
- FETCH_WIDTH, 2, narrow words per wide input word; must be >= 1.

Ports:
- clk  input  1  clock.
- wrst_n  input  1  reset, synchronous, active-low.
- sender_data  input  FETCH_WIDTH*DATA_WIDTH  wide word from upstream; valid when sender_empty_n=1.
- sender_empty_n  input  1  upstream has a word available.
- sender_deq  output  1  pops upstream; sender_data is captured on this clk edge.
- receiver_data  output  DATA_WIDTH  current narrow word.
- receiver_full_n  input  1  downstream can accept a word.
- receiver_enq  output  1  writes receiver_data downstream this cycle.
- receiver_last  output  1  high with receiver_enq on the final narrow word of a wide word.
- busy  output  1  holding register contains untransmitted words.

Behaviour:
- State: shift register sreg (FETCH_WIDTH*DATA_WIDTH bits), counter cnt (clog2(FETCH_WIDTH+1) bits) = number of words remaining, valid = (cnt != 0). No other state.
- Reset (wrst_n=0 at posedge): cnt<=0 and sreg<=0. While wrst_n=0, sender_deq=0 and receiver_enq=0 combinationally. receiver_data=0 and receiver_last=0 after reset; busy=0.
- Word order: little-end first. Word k is sender_data[(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH], for k=0..FETCH_WIDTH-1. This matches the aggregator packing, so aggregator(disaggregator(x)) = x.
- Outputs are combinational from registers and inputs:
  - receiver_data = sreg[DATA_WIDTH-1:0].
  - receiver_enq = wrst_n & valid & receiver_full_n.
  - receiver_last = receiver_enq & (cnt==1).
  - busy = valid.
- sender_deq = wrst_n & sender_empty_n & (!valid | (receiver_enq & cnt==1)).
- Sequential update at posedge, when wrst_n=1:
  - If sender_deq: sreg<=sender_data, cnt<=FETCH_WIDTH. This takes priority over the shift.
  - Else if receiver_enq: sreg<=sreg>>DATA_WIDTH (zero fill), cnt<=cnt-1.
  - Otherwise hold.
- Latency: deq at edge N; word 0 can be enqueued in cycle N+1.
- Throughput: one narrow word per cycle under no backpressure. A back-to-back wide word loads on the same edge as the last narrow word of the previous one, with no bubble. Sustained rate is FETCH_WIDTH cycles per wide word.
- Backpressure: when receiver_full_n=0, sreg and cnt hold and receiver_data stays stable. No word is dropped or duplicated.
- Empty upstream: while idle with sender_empty_n=0, nothing changes. sender_deq is never asserted when sender_empty_n=0.
- Simultaneous last enq and upstream valid: the last word is written and the new word is loaded on the same edge.
- Last enq with upstream empty: cnt->0 and the block goes idle.
- Reset mid-word: remaining words are discarded and the block goes idle. No enq or deq is issued in the reset cycle.
- FETCH_WIDTH=1: acts as a one-entry pipeline register. receiver_last equals receiver_enq.

Test Plan:
- Basic (DATA_WIDTH=11, FETCH_WIDTH=2): one word sender_data={11'd3,11'd5}, receiver_full_n=1 -> sender_deq for exactly 1 cycle. Next two cycles enq 5 (last=0) then 3 (last=1). Then busy=0, and no further enq or deq.
- Back-to-back: upstream always non-empty with words {2,1},{4,3},{6,5} -> enq stream 1,2,3,4,5,6 on 6 consecutive cycles. sender_deq pulses on cycles 0, 2 and 4 only.
- Backpressure: toggle receiver_full_n randomly ($urandom%2) over 200 random wide words -> receiver stream equals the concatenated little-end-first words exactly. receiver_data is stable while full_n=0, and there are zero enq while full_n=0.
- Reset mid-operation: assert wrst_n=0 for 1 cycle right after word 0 is enqueued -> word 1 is never enqueued, busy=0 and receiver_data=0 next cycle. The next upstream word is sent cleanly.
- Round trip: disaggregator -> async_fifo1 (DSIZE=11, ASIZE=4) -> aggregator, with random stall on both sides, over 500 words -> aggregator output matches the input sequence bit-exact and in order.
- FETCH_WIDTH=1 instance: words 7, 9, 11 back-to-back -> enq 7, 9, 11 on consecutive cycles, each with receiver_last=1.

Source files
------------

// File: rtl/disaggregator_if.sv
// Link bundle for the disaggregator: wide FIFO-style read side from the
// upstream sender and narrow FIFO-style write side into the receiver.
interface disaggregator_if #(
    parameter int DATA_WIDTH  = 11,
    parameter int FETCH_WIDTH = 2
);
    // Upstream (sender) side: wide word popped with sender_deq.
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
    logic                              sender_empty_n;
    logic                              sender_deq;

    // Downstream (receiver) side: one narrow word per receiver_enq.
    logic [DATA_WIDTH-1:0]             receiver_data;
    logic                              receiver_full_n;
    logic                              receiver_enq;
    logic                              receiver_last;

    // Status.
    logic                              busy;

    // Environment view: drives the FIFO status and wide data, observes the block.
    modport master (
        output sender_data,
        output sender_empty_n,
        output receiver_full_n,
        input  sender_deq,
        input  receiver_data,
        input  receiver_enq,
        input  receiver_last,
        input  busy
    );

    // Block view: the disaggregator itself.
    modport slave (
        input  sender_data,
        input  sender_empty_n,
        input  receiver_full_n,
        output sender_deq,
        output receiver_data,
        output receiver_enq,
        output receiver_last,
        output busy
    );
endinterface

// File: rtl/disaggregator.sv
// Disaggregator: pops one wide word of FETCH_WIDTH x DATA_WIDTH bits from an
// upstream FIFO and replays it as FETCH_WIDTH narrow words, least significant
// word first, into a downstream FIFO. A new wide word loads on the same edge
// as the last narrow word of the previous one, so a continuously fed link
// sustains one narrow word per cycle.
module disaggregator #(
    parameter int DATA_WIDTH  = 11,
    parameter int FETCH_WIDTH = 2
) (
    input  logic          clk,
    input  logic          wrst_n,
    disaggregator_if.slave bus
);
    localparam int WIDE_WIDTH = FETCH_WIDTH * DATA_WIDTH;
    localparam int CNT_WIDTH  = $clog2(FETCH_WIDTH + 1);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FETCH_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Holding register; bits [DATA_WIDTH-1:0] are always the next word out.
    logic [WIDE_WIDTH-1:0] sreg;
    // Number of narrow words still to be written downstream.
    logic [CNT_WIDTH-1:0]  cnt;

    logic                  valid;
    logic                  enq;
    logic                  on_last;
    logic                  deq;
    logic [WIDE_WIDTH-1:0] sreg_shifted;

    // Drop the word just written and zero-fill from the top. With a single
    // word per fetch there is nothing left after the shift.
    generate
        if (FETCH_WIDTH == 1) begin : g_shift_single
            assign sreg_shifted = '0;
        end else begin : g_shift_multi
            assign sreg_shifted = {{DATA_WIDTH{1'b0}}, sreg[WIDE_WIDTH-1:DATA_WIDTH]};
        end
    endgenerate

    // Handshake decode: write whenever a word is held and the receiver has
    // room; pop upstream when empty or when the final held word leaves now.
    always_comb begin
        valid   = (cnt != '0);
        enq     = wrst_n & valid & bus.receiver_full_n;
        on_last = enq & (cnt == CNT_ONE);
        deq     = wrst_n & bus.sender_empty_n & (~valid | on_last);
    end

    assign bus.receiver_data = sreg[DATA_WIDTH-1:0];
    assign bus.receiver_enq  = enq;
    assign bus.receiver_last = on_last;
    assign bus.sender_deq    = deq;
    assign bus.busy          = valid;

    // Load a fresh wide word (priority) or shift out the word just written.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!wrst_n) begin
            // NOTE: the data register is reset too, because receiver_data is
            // observable and must read zero after reset, not stale contents.
            sreg <= '0;
            cnt  <= '0;
        end else if (deq) begin
            sreg <= bus.sender_data;
            cnt  <= CNT_FULL;
        end else if (enq) begin
            sreg <= sreg_shifted;
            cnt  <= cnt - CNT_ONE;
        end
    end

    // Protocol properties: never pop an empty upstream, never push into a
    // full receiver, and last only ever accompanies a write.
    assert property (@(posedge clk) !bus.sender_empty_n |-> !bus.sender_deq)
        else $error("sender_deq asserted while sender_empty_n is low");
    assert property (@(posedge clk) !bus.receiver_full_n |-> !bus.receiver_enq)
        else $error("receiver_enq asserted while receiver_full_n is low");
    assert property (@(posedge clk) bus.receiver_last |-> bus.receiver_enq)
        else $error("receiver_last asserted without receiver_enq");

endmodule

// File: tb/tb_disaggregator.sv
// Self-checking bench for the disaggregator. A queue-based model holds the
// narrow words not yet written downstream; each scenario compares the DUT
// against it or against directed constants.
module tb_disaggregator;
    localparam int DW = 11;
    localparam int FW = 2;
    localparam int WW = DW * FW;

    logic clk = 1'b0;
    logic wrst_n = 1'b0;
    always #5 clk = ~clk;

    disaggregator_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) bus ();
    disaggregator_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(1))  bus1 ();

    disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
        .clk    (clk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(1)) dut1 (
        .clk    (clk),
        .wrst_n (wrst_n),
        .bus    (bus1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: narrow words still owed to the receiver, oldest first.
    logic [DW-1:0] pend[$];

    function automatic bit m_enq();
        return wrst_n && pend.size() != 0 && bus.receiver_full_n;
    endfunction

    function automatic bit m_last();
        return m_enq() && pend.size() == 1;
    endfunction

    function automatic bit m_deq();
        return wrst_n && bus.sender_empty_n && (pend.size() == 0 || m_last());
    endfunction

    function automatic bit m_busy();
        return pend.size() != 0;
    endfunction

    function automatic logic [DW-1:0] m_data();
        return (pend.size() != 0) ? pend[0] : '0;
    endfunction

    function automatic logic [DW+3:0] m_vec();
        return {m_deq(), m_enq(), m_last(), m_busy(), m_data()};
    endfunction

    function automatic logic [DW+3:0] dut_vec();
        return {bus.sender_deq, bus.receiver_enq, bus.receiver_last, bus.busy, bus.receiver_data};
    endfunction

    // Model update on each rising edge from the pre-edge view.
    always @(posedge clk) begin : model
        bit d;
        bit e;
        d = m_deq();
        e = m_enq();
        if (!wrst_n) begin
            pend.delete();
        end else if (d) begin
            pend.delete();
            for (int k = 0; k < FW; k++) pend.push_back(bus.sender_data[k*DW +: DW]);
        end else if (e) begin
            void'(pend.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0;
        bus.sender_empty_n  = 1'b1;
        bus.receiver_full_n = 1'b1;
        bus.sender_data     = WW'($urandom);
        for (int i = 0; i < 2; i++) begin
            #4;
            checks++;
            if (bus.sender_deq !== 1'b0 || bus.receiver_enq !== 1'b0) begin
                errors++;
                $display("FAIL reset_handshake got deq=%b enq=%b want 0 0", bus.sender_deq, bus.receiver_enq);
            end
            next_cycle();
        end
        wrst_n = 1'b1;
        bus.sender_empty_n = 1'b0;
        #4;
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_state got %h want 0", dut_vec());
        end
        next_cycle();
    endtask

    task automatic test_basic();
        bus.sender_data     = {11'd3, 11'd5};
        bus.sender_empty_n  = 1'b1;
        bus.receiver_full_n = 1'b1;
        #4;
        checks++;
        if (bus.sender_deq !== 1'b1 || bus.receiver_enq !== 1'b0) begin
            errors++;
            $display("FAIL basic_deq got deq=%b enq=%b want 1 0", bus.sender_deq, bus.receiver_enq);
        end
        next_cycle();
        bus.sender_empty_n = 1'b0;
        #4;
        checks++;
        if ({bus.sender_deq, bus.receiver_enq, bus.receiver_last, bus.receiver_data} !== {3'b010, 11'd5}) begin
            errors++;
            $display("FAIL basic_word0 got deq=%b enq=%b last=%b data=%0d want 0 1 0 5",
                     bus.sender_deq, bus.receiver_enq, bus.receiver_last, bus.receiver_data);
        end
        next_cycle();
        #4;
        checks++;
        if ({bus.sender_deq, bus.receiver_enq, bus.receiver_last, bus.receiver_data} !== {3'b011, 11'd3}) begin
            errors++;
            $display("FAIL basic_word1 got deq=%b enq=%b last=%b data=%0d want 0 1 1 3",
                     bus.sender_deq, bus.receiver_enq, bus.receiver_last, bus.receiver_data);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++;
            if (bus.busy !== 1'b0 || bus.receiver_enq !== 1'b0 || bus.sender_deq !== 1'b0) begin
                errors++;
                $display("FAIL basic_idle got busy=%b enq=%b deq=%b want 0 0 0",
                         bus.busy, bus.receiver_enq, bus.sender_deq);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [WW-1:0] words[3];
        bit            exp_deq[8]  = '{1, 0, 1, 0, 1, 0, 0, 0};
        bit            exp_enq[8]  = '{0, 1, 1, 1, 1, 1, 1, 0};
        bit            exp_last[8] = '{0, 0, 1, 0, 1, 0, 1, 0};
        int            exp_dat[8]  = '{0, 1, 2, 3, 4, 5, 6, 0};
        int            idx = 0;
        bit            popped;
        words[0] = {11'd2, 11'd1};
        words[1] = {11'd4, 11'd3};
        words[2] = {11'd6, 11'd5};
        bus.receiver_full_n = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            bus.sender_empty_n = (idx < 3);
            bus.sender_data    = words[(idx < 3) ? idx : 0];
            #4;
            checks++;
            if (bus.sender_deq !== exp_deq[cyc] || bus.receiver_enq !== exp_enq[cyc] ||
                bus.receiver_last !== exp_last[cyc] ||
                (exp_enq[cyc] && bus.receiver_data !== DW'(exp_dat[cyc]))) begin
                errors++;
                $display("FAIL b2b_cycle%0d got deq=%b enq=%b last=%b data=%0d want %b %b %b %0d", cyc,
                         bus.sender_deq, bus.receiver_enq, bus.receiver_last, bus.receiver_data,
                         exp_deq[cyc], exp_enq[cyc], exp_last[cyc], exp_dat[cyc]);
            end
            popped = bus.sender_deq;
            next_cycle();
            if (popped) idx++;
        end
        bus.sender_empty_n = 1'b0;
    endtask

    task automatic test_backpressure(input int n_words);
        logic [DW-1:0] stream[$];
        logic [WW-1:0] cur;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] want;
        bit            prev_hold = 1'b0;
        bit            popped;
        int            sent = 0;
        int            budget = 0;
        cur = WW'($urandom);
        while (sent < n_words || stream.size() != 0) begin
            bus.receiver_full_n = 1'($urandom % 2);
            bus.sender_empty_n  = (sent < n_words);
            bus.sender_data     = cur;
            #4;
            checks++;
            if (dut_vec() !== m_vec()) begin
                errors++;
                $display("FAIL bp_model got %h want %h", dut_vec(), m_vec());
            end
            if (!bus.receiver_full_n) begin
                checks++;
                if (bus.receiver_enq !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_enq_while_full got %b want 0", bus.receiver_enq);
                end
            end
            if (prev_hold) begin
                checks++;
                if (bus.receiver_data !== prev_data) begin
                    errors++;
                    $display("FAIL bp_stable got %h want %h", bus.receiver_data, prev_data);
                end
            end
            if (bus.receiver_enq === 1'b1) begin
                want = (stream.size() != 0) ? stream.pop_front() : 'x;
                checks++;
                if (bus.receiver_data !== want) begin
                    errors++;
                    $display("FAIL bp_stream got %h want %h", bus.receiver_data, want);
                end
            end
            prev_hold = !bus.receiver_full_n && bus.busy;
            prev_data = bus.receiver_data;
            popped    = bus.sender_deq;
            if (popped) begin
                for (int k = 0; k < FW; k++) stream.push_back(cur[k*DW +: DW]);
            end
            next_cycle();
            if (popped) begin
                sent++;
                cur = WW'($urandom);
            end
            budget++;
            if (budget > 4000) begin
                checks++;
                errors++;
                $display("FAIL bp_timeout got sent=%0d want %0d", sent, n_words);
                break;
            end
        end
        bus.sender_empty_n  = 1'b0;
        bus.receiver_full_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        bus.receiver_full_n = 1'b1;
        bus.sender_data     = {11'h2AB, 11'h155};
        bus.sender_empty_n  = 1'b1;
        next_cycle();
        bus.sender_empty_n = 1'b0;
        #4;
        checks++;
        if (bus.receiver_enq !== 1'b1 || bus.receiver_data !== 11'h155) begin
            errors++;
            $display("FAIL rmid_word0 got enq=%b data=%h want 1 155", bus.receiver_enq, bus.receiver_data);
        end
        next_cycle();
        wrst_n = 1'b0;
        bus.sender_data    = {11'h0F0, 11'h70F};
        bus.sender_empty_n = 1'b1;
        #4;
        checks++;
        if (bus.receiver_enq !== 1'b0 || bus.sender_deq !== 1'b0) begin
            errors++;
            $display("FAIL rmid_in_reset got enq=%b deq=%b want 0 0", bus.receiver_enq, bus.sender_deq);
        end
        next_cycle();
        wrst_n = 1'b1;
        #4;
        checks++;
        if (bus.busy !== 1'b0 || bus.receiver_data !== '0 || bus.sender_deq !== 1'b1) begin
            errors++;
            $display("FAIL rmid_after got busy=%b data=%h deq=%b want 0 0 1",
                     bus.busy, bus.receiver_data, bus.sender_deq);
        end
        next_cycle();
        bus.sender_empty_n = 1'b0;
        #4;
        checks++;
        if (bus.receiver_enq !== 1'b1 || bus.receiver_data !== 11'h70F || bus.receiver_last !== 1'b0) begin
            errors++;
            $display("FAIL rmid_next0 got enq=%b data=%h last=%b want 1 70f 0",
                     bus.receiver_enq, bus.receiver_data, bus.receiver_last);
        end
        next_cycle();
        #4;
        checks++;
        if (bus.receiver_enq !== 1'b1 || bus.receiver_data !== 11'h0F0 || bus.receiver_last !== 1'b1) begin
            errors++;
            $display("FAIL rmid_next1 got enq=%b data=%h last=%b want 1 0f0 1",
                     bus.receiver_enq, bus.receiver_data, bus.receiver_last);
        end
        next_cycle();
    endtask

    // Reassembles the narrow stream the way the aggregator would and checks
    // it against the wide words handed upstream, with stalls on both sides.
    task automatic test_round_trip(input int n_words);
        logic [WW-1:0] sent_q[$];
        logic [WW-1:0] cur;
        logic [WW-1:0] acc = '0;
        logic [WW-1:0] want;
        int            part = 0;
        int            sent = 0;
        int            got = 0;
        int            budget = 0;
        bit            popped;
        cur = WW'($urandom);
        while (got < n_words) begin
            bus.sender_empty_n  = (sent < n_words) && ($urandom % 4 != 0);
            bus.receiver_full_n = ($urandom % 3 != 0);
            bus.sender_data     = cur;
            #4;
            if (bus.receiver_enq === 1'b1) begin
                acc[part*DW +: DW] = bus.receiver_data;
                checks++;
                if (bus.receiver_last !== (part == FW - 1)) begin
                    errors++;
                    $display("FAIL rt_last got %b want %b", bus.receiver_last, part == FW - 1);
                end
                if (part == FW - 1) begin
                    want = (sent_q.size() != 0) ? sent_q.pop_front() : 'x;
                    checks++;
                    if (acc !== want) begin
                        errors++;
                        $display("FAIL rt_word%0d got %h want %h", got, acc, want);
                    end
                    got++;
                    part = 0;
                end else begin
                    part++;
                end
            end
            popped = bus.sender_deq;
            if (popped) sent_q.push_back(cur);
            next_cycle();
            if (popped) begin
                sent++;
                cur = WW'($urandom);
            end
            budget++;
            if (budget > 8000) begin
                checks++;
                errors++;
                $display("FAIL rt_timeout got words=%0d want %0d", got, n_words);
                break;
            end
        end
        bus.sender_empty_n  = 1'b0;
        bus.receiver_full_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_fetch1();
        int words[3]    = '{7, 9, 11};
        bit exp_deq[5]  = '{1, 1, 1, 0, 0};
        bit exp_enq[5]  = '{0, 1, 1, 1, 0};
        int exp_dat[5]  = '{0, 7, 9, 11, 0};
        int idx = 0;
        bit popped;
        bus1.receiver_full_n = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            bus1.sender_empty_n = (idx < 3);
            bus1.sender_data    = DW'(words[(idx < 3) ? idx : 0]);
            #4;
            checks++;
            if (bus1.sender_deq !== exp_deq[cyc] || bus1.receiver_enq !== exp_enq[cyc] ||
                bus1.receiver_last !== exp_enq[cyc] ||
                (exp_enq[cyc] && bus1.receiver_data !== DW'(exp_dat[cyc]))) begin
                errors++;
                $display("FAIL fw1_cycle%0d got deq=%b enq=%b last=%b data=%0d want %b %b %b %0d", cyc,
                         bus1.sender_deq, bus1.receiver_enq, bus1.receiver_last, bus1.receiver_data,
                         exp_deq[cyc], exp_enq[cyc], exp_enq[cyc], exp_dat[cyc]);
            end
            popped = bus1.sender_deq;
            next_cycle();
            if (popped) idx++;
        end
        bus1.sender_empty_n = 1'b0;
    endtask

    initial begin
        bus.sender_data      = '0;
        bus.sender_empty_n   = 1'b0;
        bus.receiver_full_n  = 1'b1;
        bus1.sender_data     = '0;
        bus1.sender_empty_n  = 1'b0;
        bus1.receiver_full_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure(200);
        test_reset_mid();
        test_round_trip(250);
        test_fetch1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
